// File: rtl/aes_block_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes_block_loader                                                |
// | Purpose  : Packs a byte stream into one AES key/state block of WORDS x 32  |
// |            bits. The first accepted byte lands in the most significant     |
// |            byte of word 0. A completed block is held until the consumer    |
// |            takes it; a block cut short by in_last is dropped and flagged.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   1          rising-edge clock                             |
// |   rst        in   1          asynchronous active-high reset                |
// |   clr        in   1          synchronous abort, drops partial/held block   |
// |   byte_in    in   8          data byte                                     |
// |   in_valid   in   1          byte_in valid                                 |
// |   in_ready   out  1          loader can take a byte (FILL state)           |
// |   in_last    in   1          final byte of the source block                |
// |   out_block  out  32*WORDS   assembled block, word 0 in the MS 32 bits     |
// |   out_valid  out  1          out_block complete and held (FULL state)      |
// |   out_ready  in   1          consumer takes out_block                      |
// |   fill_cnt   out  FILL_W     bytes accepted into the current block         |
// |   err_short  out  1          one-cycle pulse when a short block is dropped |
// |   blk_cnt    out  16         completed handshakes (AES_LOADER_CNT_EN only) |
// | Optional build macro: AES_LOADER_CNT_EN adds the blk_cnt output/counter.   |
// +----------------------------------------------------------------------------+
module aes_block_loader #(
  parameter int WORDS  = 4,
  parameter int FILL_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [7:0]          byte_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  output logic [32*WORDS-1:0] out_block,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FILL_W-1:0]   fill_cnt,
  output logic                err_short
`ifdef AES_LOADER_CNT_EN
  ,
  output logic [15:0]         blk_cnt
`endif
);

  localparam int                c_NBYTES   = 4 * WORDS;
  localparam int                c_BITS     = 32 * WORDS;
  localparam logic [FILL_W-1:0] c_LAST_IDX = FILL_W'(c_NBYTES - 1);
  localparam logic [FILL_W-1:0] c_FULL_CNT = FILL_W'(c_NBYTES);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [c_BITS-1:0]   block_q, block_d;
  logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic                err_short_q, err_short_d;
  logic [c_BITS-1:0]   w_block_wr;
`ifdef AES_LOADER_CNT_EN
  logic [15:0]         blk_cnt_q, blk_cnt_d;
`endif

  // Current block with byte_in merged at the slot selected by fill_cnt.
  // Constant part-selects keep the write mux explicit for synthesis.
  always_comb begin
    w_block_wr = block_q;
    for (int i = 0; i < c_NBYTES; i++) begin
      if (fill_cnt_q == FILL_W'(i)) begin
        w_block_wr[c_BITS-1-8*i -: 8] = byte_in;
      end
    end
  end

  // Next-state logic. clr overrides everything; in FULL the byte side is
  // ignored entirely, so in_valid only matters in FILL.
  always_comb begin
    state_d     = state_q;
    block_d     = block_q;
    fill_cnt_d  = fill_cnt_q;
    err_short_d = 1'b0;
`ifdef AES_LOADER_CNT_EN
    blk_cnt_d   = blk_cnt_q;
`endif
    if (clr) begin
      state_d    = S_FILL;
      block_d    = '0;
      fill_cnt_d = '0;
    end else if (state_q == S_FULL) begin
      if (out_ready) begin
        state_d    = S_FILL;
        block_d    = '0;
        fill_cnt_d = '0;
`ifdef AES_LOADER_CNT_EN
        blk_cnt_d  = blk_cnt_q + 16'd1;
`else
        // no block counter in this build
`endif
      end
    end else if (in_valid) begin
      if (fill_cnt_q == c_LAST_IDX) begin
        // Completing byte: in_last here is a normal end of block.
        state_d    = S_FULL;
        block_d    = w_block_wr;
        fill_cnt_d = c_FULL_CNT;
      end else if (in_last) begin
        block_d     = '0;
        fill_cnt_d  = '0;
        err_short_d = 1'b1;
      end else begin
        block_d    = w_block_wr;
        fill_cnt_d = fill_cnt_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      block_q     <= '0;
      fill_cnt_q  <= '0;
      err_short_q <= 1'b0;
`ifdef AES_LOADER_CNT_EN
      blk_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      block_q     <= block_d;
      fill_cnt_q  <= fill_cnt_d;
      err_short_q <= err_short_d;
`ifdef AES_LOADER_CNT_EN
      blk_cnt_q   <= blk_cnt_d;
`endif
    end
  end

  // in_ready is gated by rst directly so it is low for the whole reset pulse
  // and high in the very first cycle after release.
  assign in_ready  = (state_q == S_FILL) && !rst;
  assign out_valid = (state_q == S_FULL);
  assign out_block = block_q;
  assign fill_cnt  = fill_cnt_q;
  assign err_short = err_short_q;
`ifdef AES_LOADER_CNT_EN
  assign blk_cnt   = blk_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_block_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_aes_block_loader                                             |
// | Purpose  : Self-checking bench for aes_block_loader (WORDS=4 and WORDS=8). |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_aes_block_loader;

  localparam int NB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WORDS=4 instance
  logic         clr = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [7:0]   byte_in = 0;
  logic         in_ready, out_valid, err_short;
  logic [127:0] out_block;
  logic [5:0]   fill_cnt;
  // WORDS=8 instance
  logic         clr8 = 0, in_valid8 = 0, in_last8 = 0, out_ready8 = 0;
  logic [7:0]   byte_in8 = 0;
  logic         in_ready8, out_valid8, err_short8;
  logic [255:0] out_block8;
  logic [5:0]   fill_cnt8;
`ifdef AES_LOADER_CNT_EN
  logic [15:0]  blk_cnt, blk_cnt8;
`endif

  aes_block_loader #(.WORDS(4), .FILL_W(6)) dut (
    .clk(clk), .rst(rst), .clr(clr), .byte_in(byte_in), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .out_block(out_block),
    .out_valid(out_valid), .out_ready(out_ready), .fill_cnt(fill_cnt),
    .err_short(err_short)
`ifdef AES_LOADER_CNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  aes_block_loader #(.WORDS(8), .FILL_W(6)) dut8 (
    .clk(clk), .rst(rst), .clr(clr8), .byte_in(byte_in8), .in_valid(in_valid8),
    .in_ready(in_ready8), .in_last(in_last8), .out_block(out_block8),
    .out_valid(out_valid8), .out_ready(out_ready8), .fill_cnt(fill_cnt8),
    .err_short(err_short8)
`ifdef AES_LOADER_CNT_EN
    , .blk_cnt(blk_cnt8)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: list of accepted bytes, a "full" flag, expected pulse.
  logic [7:0] m_bytes [NB];
  int         m_len = 0;
  bit         m_full = 0;
  bit         m_err = 0;
  int         m_blocks = 0;

  task automatic model_reset();
    m_len = 0; m_full = 0; m_err = 0; m_blocks = 0;
  endtask

  task automatic model_step();
    m_err = 0;
    if (clr) begin
      m_len = 0; m_full = 0;
    end else if (m_full) begin
      if (out_ready) begin m_len = 0; m_full = 0; m_blocks++; end
    end else if (in_valid) begin
      m_bytes[m_len] = byte_in;
      m_len++;
      if (m_len == NB) m_full = 1;
      else if (in_last) begin m_len = 0; m_err = 1; end
    end
  endtask

  // Bytes concatenated MS-first, unused tail zero.
  function automatic logic [127:0] m_block();
    logic [127:0] b = '0;
    for (int i = 0; i < m_len; i++)
      b = b | ({120'd0, m_bytes[i]} << (8 * (NB - 1 - i)));
    return b;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || fill_cnt !== 6'd0 || out_block !== 128'd0 || err_short !== 1'b0) begin
      errors++; $display("FAIL rst_outputs got v=%b cnt=%0d blk=%h e=%b exp zeros", out_valid, fill_cnt, out_block, err_short);
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
    checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1; in_valid = 1;
    for (int b = 0; b < 16; b++) begin
      byte_in = 8'(b);
      tick();
      if (b < 15) begin
        if (fill_cnt !== 6'(b + 1) || out_valid !== 1'b0) begin
          errors++; $display("FAIL basic_fill got cnt=%0d v=%b exp cnt=%0d v=0", fill_cnt, out_valid, b + 1);
        end
        checks++;
      end
    end
    in_valid = 0;
    if (out_valid !== 1'b1 || out_block !== 128'h000102030405060708090A0B0C0D0E0F) begin
      errors++; $display("FAIL basic_block got v=%b %h", out_valid, out_block);
    end
    checks++;
    tick();
    if (out_valid !== 1'b0 || fill_cnt !== 6'd0 || out_block !== 128'd0) begin
      errors++; $display("FAIL basic_release got v=%b cnt=%0d blk=%h exp 0/0/0", out_valid, fill_cnt, out_block);
    end
    checks++;
  endtask

  task automatic test_backpressure();
    logic [127:0] exp = '0;
    out_ready = 0; in_valid = 1;
    for (int b = 0; b < 16; b++) begin
      byte_in = 8'($urandom);
      exp = {exp[119:0], byte_in};
      tick();
    end
    byte_in = 8'hAA;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_block !== exp || fill_cnt !== 6'd16) begin
        errors++; $display("FAIL hold got rdy=%b v=%b cnt=%0d blk=%h exp 0 1 16 %h", in_ready, out_valid, fill_cnt, out_block, exp);
      end
      checks++;
    end
    in_valid = 0; out_ready = 1;
    tick();
    out_ready = 0;
    if (out_valid !== 1'b0 || fill_cnt !== 6'd0 || out_block !== 128'd0) begin
      errors++; $display("FAIL hold_release got v=%b cnt=%0d blk=%h exp zeros", out_valid, fill_cnt, out_block);
    end
    checks++;
  endtask

  task automatic test_short();
    out_ready = 0; in_valid = 1;
    for (int b = 0; b < 7; b++) begin
      byte_in = 8'($urandom); in_last = (b == 6);
      tick();
    end
    in_valid = 0; in_last = 0;
    if (err_short !== 1'b1 || fill_cnt !== 6'd0 || out_block !== 128'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL short_abort got e=%b cnt=%0d blk=%h v=%b exp 1 0 0 0", err_short, fill_cnt, out_block, out_valid);
    end
    checks++;
    tick();
    if (err_short !== 1'b0) begin errors++; $display("FAIL short_pulse_width got %b exp 0", err_short); end
    checks++;
    in_valid = 1;
    for (int b = 0; b < 16; b++) begin
      byte_in = 8'(8'h10 + b); in_last = (b == 15);
      tick();
    end
    in_valid = 0; in_last = 0;
    if (out_valid !== 1'b1 || err_short !== 1'b0 || out_block !== 128'h101112131415161718191A1B1C1D1E1F) begin
      errors++; $display("FAIL short_next got v=%b e=%b %h", out_valid, err_short, out_block);
    end
    checks++;
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_words8();
    out_ready8 = 0; in_valid8 = 1;
    for (int b = 0; b < 32; b++) begin
      byte_in8 = 8'(8'h20 + b);
      @(posedge clk); #1;
      if (b == 30 && out_valid8 !== 1'b0) begin errors++; $display("FAIL w8_early got v=%b exp 0", out_valid8); end
      if (b == 30) checks++;
    end
    in_valid8 = 0;
    if (out_valid8 !== 1'b1 || fill_cnt8 !== 6'd32 ||
        out_block8 !== 256'h202122232425262728292A2B2C2D2E2F303132333435363738393A3B3C3D3E3F) begin
      errors++; $display("FAIL w8_block got v=%b cnt=%0d %h", out_valid8, fill_cnt8, out_block8);
    end
    checks++;
    out_ready8 = 1; @(posedge clk); #1; out_ready8 = 0;
    if (out_valid8 !== 1'b0 || fill_cnt8 !== 6'd0) begin
      errors++; $display("FAIL w8_release got v=%b cnt=%0d", out_valid8, fill_cnt8);
    end
    checks++;
  endtask

  task automatic test_async_reset_clr();
    out_ready = 0; in_valid = 1;
    for (int b = 0; b < 9; b++) begin byte_in = 8'($urandom); tick(); end
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    if (out_block !== 128'd0 || fill_cnt !== 6'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || err_short !== 1'b0) begin
      errors++; $display("FAIL async_rst got blk=%h cnt=%0d v=%b rdy=%b e=%b exp zeros", out_block, fill_cnt, out_valid, in_ready, err_short);
    end
    checks++;
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    in_valid = 1;
    for (int b = 0; b < 16; b++) begin byte_in = 8'($urandom); tick(); end
    in_valid = 0;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_pre got v=%b exp 1", out_valid); end
    checks++;
    clr = 1; in_valid = 1; byte_in = 8'h55;
    tick();
    clr = 0; in_valid = 0;
    if (out_valid !== 1'b0 || fill_cnt !== 6'd0 || out_block !== 128'd0 || err_short !== 1'b0) begin
      errors++; $display("FAIL clr_full got v=%b cnt=%0d blk=%h e=%b exp zeros", out_valid, fill_cnt, out_block, err_short);
    end
    checks++;
    in_valid = 1;
    for (int b = 0; b < 16; b++) begin byte_in = 8'($urandom); tick(); end
    in_valid = 0;
    if (out_valid !== 1'b1 || out_block !== m_block()) begin
      errors++; $display("FAIL clr_after got v=%b %h exp %h", out_valid, out_block, m_block());
    end
    checks++;
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      clr       = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_last   = ($urandom_range(0, 11) == 0);
      out_ready = $urandom_range(0, 1);
      byte_in   = 8'($urandom);
      tick();
      if (out_valid !== m_full || in_ready !== !m_full || fill_cnt !== 6'(m_len) ||
          out_block !== m_block() || err_short !== m_err) begin
        errors++;
        $display("FAIL random n=%0d got v=%b r=%b cnt=%0d e=%b blk=%h exp v=%b cnt=%0d e=%b blk=%h",
                 n, out_valid, in_ready, fill_cnt, err_short, out_block, m_full, m_len, m_err, m_block());
      end
      checks++;
`ifdef AES_LOADER_CNT_EN
      if (blk_cnt !== 16'(m_blocks)) begin
        errors++; $display("FAIL random_blk_cnt got %0d exp %0d", blk_cnt, 16'(m_blocks));
      end
      checks++;
`endif
    end
    clr = 0; in_valid = 0; in_last = 0;
    out_ready = 1; tick(); out_ready = 0;
  endtask

`ifdef AES_LOADER_CNT_EN
  task automatic test_blk_cnt();
    logic [15:0] base = blk_cnt;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1;
      for (int b = 0; b < ((k == 2) ? 5 : 16); b++) begin
        byte_in = 8'($urandom); in_last = (k == 2 && b == 4);
        tick();
      end
      in_valid = 0; in_last = 0;
      out_ready = 1; tick(); out_ready = 0;
    end
    if (blk_cnt !== base + 16'd3) begin
      errors++; $display("FAIL blk_cnt got %0d exp %0d", blk_cnt, base + 16'd3);
    end
    checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short();
    test_words8();
    test_async_reset_clr();
    test_random();
`ifdef AES_LOADER_CNT_EN
    test_blk_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
